uart_host_bridge: RTL and testbench

//  Host-side initiator for the turret UART core's parallel CSN/WEN/OEN port.

---
 rtl/uart_host_bridge_if.sv | 23 ++
 rtl/uart_host_bridge.sv | 182 ++++++++++++++++++
 tb/tb_uart_host_bridge.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_host_bridge_if.sv
// Host-side byte streams of the UART host bridge: a tx byte stream into the bridge
// and an rx byte stream (with error tag) out of it.
interface uart_host_bridge_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_err;
  logic       rx_valid;
  logic       rx_ready;

  // master: the host logic producing tx bytes and consuming rx bytes
  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_err, rx_valid
  );

  // slave: the bridge itself
  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_err, rx_valid
  );
endinterface

// File: rtl/uart_host_bridge.sv
// Host initiator for the UART core's CSN/WEN/OEN parallel port: tx stream -> write strobes,
// RXRDY -> read strobes -> rx stream. Optional macro UART_HOST_ERR_DROP_EN discards errored bytes.
module uart_host_bridge #(
  parameter int unsigned TX_SETTLE = 2,
  parameter int unsigned RX_SETTLE = 2
) (
  input  logic                 CLK,
  input  logic                 aresetn,
  uart_host_bridge_if.slave    host,
  output logic                 ovf_sticky,
  input  logic                 ovf_clr,
  output logic [7:0]           err_drop_cnt,
  output logic                 uart_csn,
  output logic                 uart_wen,
  output logic                 uart_oen,
  output logic [7:0]           uart_data_in,
  input  logic [7:0]           uart_data_out,
  input  logic                 uart_txrdy,
  input  logic                 uart_rxrdy,
  input  logic                 uart_parity_err,
  input  logic                 uart_framing_err,
  input  logic                 uart_overflow
);

  typedef enum logic [2:0] {IDLE, WR, WR_HOLD, RD, RD_HOLD} state_t;

  localparam logic       OP_WRITE    = 1'b0;
  localparam logic       OP_READ     = 1'b1;
  localparam logic [7:0] TX_SETTLE_C = 8'(TX_SETTLE);
  localparam logic [7:0] RX_SETTLE_C = 8'(RX_SETTLE);

  state_t     state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;
  logic       last_op_reg, last_op_next;
  logic       csn_reg, csn_next;
  logic       wen_reg, wen_next;
  logic       oen_reg, oen_next;
  logic [7:0] data_in_reg, data_in_next;
  logic [7:0] rx_data_reg, rx_data_next;
  logic       rx_err_reg, rx_err_next;
  logic       rx_valid_reg, rx_valid_next;
  logic       ovf_reg, ovf_next;

  logic rd_req, wr_req, sel_rd, sel_wr, rd_err;

  assign rd_req = uart_rxrdy & ~rx_valid_reg;
  assign wr_req = host.tx_valid & uart_txrdy;
  // When both want the port, the op that did not go last wins
  assign sel_rd = rd_req & (~wr_req | (last_op_reg == OP_WRITE));
  assign sel_wr = wr_req & (~rd_req | (last_op_reg == OP_READ));
  assign rd_err = uart_parity_err | uart_framing_err;

  assign host.tx_ready = (state_reg == IDLE) & uart_txrdy & sel_wr;
  assign host.rx_data  = rx_data_reg;
  assign host.rx_err   = rx_err_reg;
  assign host.rx_valid = rx_valid_reg;
  assign ovf_sticky    = ovf_reg;
  assign uart_csn      = csn_reg;
  assign uart_wen      = wen_reg;
  assign uart_oen      = oen_reg;
  assign uart_data_in  = data_in_reg;

`ifdef UART_HOST_ERR_DROP_EN
  logic [7:0] drop_cnt_reg, drop_cnt_next;
  assign err_drop_cnt = drop_cnt_reg;
`else
  assign err_drop_cnt = 8'd0;
`endif

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    last_op_next  = last_op_reg;
    csn_next      = csn_reg;
    wen_next      = wen_reg;
    oen_next      = oen_reg;
    data_in_next  = data_in_reg;
    rx_data_next  = rx_data_reg;
    rx_err_next   = rx_err_reg;
    rx_valid_next = rx_valid_reg;
`ifdef UART_HOST_ERR_DROP_EN
    drop_cnt_next = drop_cnt_reg;
`endif
    ovf_next      = uart_overflow | (ovf_reg & ~ovf_clr);

    if (rx_valid_reg && host.rx_ready) begin
      rx_valid_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        if (sel_rd) begin
          state_next = RD;
          csn_next   = 1'b0;
          oen_next   = 1'b0;
        end else if (sel_wr) begin
          state_next   = WR;
          csn_next     = 1'b0;
          wen_next     = 1'b0;
          data_in_next = host.tx_data;
        end
      end
      WR: begin
        csn_next     = 1'b1;
        wen_next     = 1'b1;
        cnt_next     = TX_SETTLE_C;
        last_op_next = OP_WRITE;
        state_next   = WR_HOLD;
      end
      RD: begin
        csn_next     = 1'b1;
        oen_next     = 1'b1;
        cnt_next     = RX_SETTLE_C;
        last_op_next = OP_READ;
        state_next   = RD_HOLD;
`ifdef UART_HOST_ERR_DROP_EN
        if (rd_err) begin
          if (drop_cnt_reg != 8'hFF) begin
            drop_cnt_next = drop_cnt_reg + 8'd1;
          end
        end else begin
          rx_data_next  = uart_data_out;
          rx_err_next   = 1'b0;
          rx_valid_next = 1'b1;
        end
`else
        rx_data_next  = uart_data_out;
        rx_err_next   = rd_err;
        rx_valid_next = 1'b1;
`endif
      end
      WR_HOLD, RD_HOLD: begin
        // Core ready flags lag the strobe; ignore them until the counter expires
        if (cnt_reg == 8'd0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge aresetn) begin
    if (!aresetn) begin
      state_reg    <= IDLE;
      cnt_reg      <= 8'd0;
      last_op_reg  <= OP_WRITE;
      csn_reg      <= 1'b1;
      wen_reg      <= 1'b1;
      oen_reg      <= 1'b1;
      data_in_reg  <= 8'd0;
      rx_data_reg  <= 8'd0;
      rx_err_reg   <= 1'b0;
      rx_valid_reg <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      last_op_reg  <= last_op_next;
      csn_reg      <= csn_next;
      wen_reg      <= wen_next;
      oen_reg      <= oen_next;
      data_in_reg  <= data_in_next;
      rx_data_reg  <= rx_data_next;
      rx_err_reg   <= rx_err_next;
      rx_valid_reg <= rx_valid_next;
      ovf_reg      <= ovf_next;
    end
  end

`ifdef UART_HOST_ERR_DROP_EN
  always_ff @(posedge CLK or negedge aresetn) begin
    if (!aresetn) begin
      drop_cnt_reg <= 8'd0;
    end else begin
      drop_cnt_reg <= drop_cnt_next;
    end
  end
`endif

endmodule

// File: tb/tb_uart_host_bridge.sv
// Directed self-checking bench for uart_host_bridge (default TX_SETTLE/RX_SETTLE = 2).
// Expectations follow the build: UART_HOST_ERR_DROP_EN selects the drop-mode checks.
module tb_uart_host_bridge;
  logic       CLK = 1'b0;
  logic       aresetn;
  logic       ovf_sticky, ovf_clr;
  logic [7:0] err_drop_cnt;
  logic       uart_csn, uart_wen, uart_oen;
  logic [7:0] uart_data_in, uart_data_out;
  logic       uart_txrdy, uart_rxrdy, uart_parity_err, uart_framing_err, uart_overflow;

  int n_tests = 0;
  int n_fail  = 0;

  uart_host_bridge_if bus ();

  uart_host_bridge #(.TX_SETTLE(2), .RX_SETTLE(2)) dut (
    .CLK              (CLK),
    .aresetn          (aresetn),
    .host             (bus.slave),
    .ovf_sticky       (ovf_sticky),
    .ovf_clr          (ovf_clr),
    .err_drop_cnt     (err_drop_cnt),
    .uart_csn         (uart_csn),
    .uart_wen         (uart_wen),
    .uart_oen         (uart_oen),
    .uart_data_in     (uart_data_in),
    .uart_data_out    (uart_data_out),
    .uart_txrdy       (uart_txrdy),
    .uart_rxrdy       (uart_rxrdy),
    .uart_parity_err  (uart_parity_err),
    .uart_framing_err (uart_framing_err),
    .uart_overflow    (uart_overflow)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int    n_strobe;
    int    n_both;
    logic  ops [4];

    aresetn          = 1'b0;
    ovf_clr          = 1'b0;
    uart_data_out    = 8'h00;
    uart_txrdy       = 1'b0;
    uart_rxrdy       = 1'b0;
    uart_parity_err  = 1'b0;
    uart_framing_err = 1'b0;
    uart_overflow    = 1'b0;
    bus.tx_data      = 8'h00;
    bus.tx_valid     = 1'b0;
    bus.rx_ready     = 1'b0;

    // Reset state
    ticks(2);
    check("rst_csn", uart_csn, 1);
    check("rst_wen", uart_wen, 1);
    check("rst_oen", uart_oen, 1);
    check("rst_data_in", uart_data_in, 0);
    check("rst_rx_valid", bus.rx_valid, 0);
    check("rst_rx_data", bus.rx_data, 0);
    check("rst_rx_err", bus.rx_err, 0);
    check("rst_ovf", ovf_sticky, 0);
    check("rst_drop_cnt", err_drop_cnt, 0);
    check("rst_tx_ready", bus.tx_ready, 0);
    aresetn = 1'b1;
    tick();
    $display("[TB] reset released");

    // Write 0x5A, then a second byte held during the settle window
    uart_txrdy   = 1'b1;
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'h5A;
    #1;
    check("tx_ready_idle", bus.tx_ready, 1);
    check("tx_no_strobe_yet", uart_csn, 1);
    tick();
    check("wr_csn", uart_csn, 0);
    check("wr_wen", uart_wen, 0);
    check("wr_oen", uart_oen, 1);
    check("wr_data", uart_data_in, 8'h5A);
    bus.tx_data = 8'h11;
    #1;
    check("tx_ready_in_wr", bus.tx_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("settle_csn", uart_csn, 1);
      check("settle_tx_ready", bus.tx_ready, 0);
    end
    tick();
    check("tx_ready_after_settle", bus.tx_ready, 1);
    tick();
    check("wr2_csn", uart_csn, 0);
    check("wr2_data", uart_data_in, 8'h11);
    bus.tx_valid = 1'b0;
    ticks(4);
    $display("[TB] tx 0x5A then 0x11 written");

    // Read 0xC3, hold it with rx_ready low while RXRDY stays high
    uart_data_out = 8'hC3;
    uart_rxrdy    = 1'b1;
    tick();
    check("rd_csn", uart_csn, 0);
    check("rd_oen", uart_oen, 0);
    check("rd_wen", uart_wen, 1);
    check("rd_rx_valid_early", bus.rx_valid, 0);
    tick();
    check("rd_rx_valid", bus.rx_valid, 1);
    check("rd_rx_data", bus.rx_data, 8'hC3);
    check("rd_rx_err", bus.rx_err, 0);
    check("rd_csn_release", uart_csn, 1);
    n_strobe = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (!uart_csn) n_strobe++;
    end
    check("rd_backpressure_strobes", n_strobe, 0);
    check("rd_rx_valid_held", bus.rx_valid, 1);
    bus.rx_ready = 1'b1;
    uart_rxrdy   = 1'b0;
    tick();
    check("rd_rx_valid_cleared", bus.rx_valid, 0);
    bus.rx_ready = 1'b0;
    $display("[TB] rx 0xC3 read and drained");

    // Both sides requesting: last op was a read, so write goes first
    bus.rx_ready  = 1'b1;
    uart_rxrdy    = 1'b1;
    uart_data_out = 8'h3C;
    bus.tx_valid  = 1'b1;
    bus.tx_data   = 8'h96;
    n_strobe = 0;
    n_both   = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!uart_wen && !uart_oen) n_both++;
      if (!uart_csn) begin
        if (n_strobe < 4) ops[n_strobe] = !uart_oen;
        n_strobe++;
      end
    end
    check("alt_nstrobe", n_strobe, 8);
    check("alt_op0_write", ops[0], 0);
    check("alt_op1_read", ops[1], 1);
    check("alt_op2_write", ops[2], 0);
    check("alt_op3_read", ops[3], 1);
    check("alt_wen_oen_both_low", n_both, 0);
    bus.tx_valid = 1'b0;
    uart_rxrdy   = 1'b0;
    ticks(6);
    bus.rx_ready = 1'b0;
    $display("[TB] alternating write/read sequence done");

    // Parity error on read
    uart_data_out   = 8'h77;
    uart_parity_err = 1'b1;
    uart_rxrdy      = 1'b1;
    tick();
    uart_rxrdy = 1'b0;
    tick();
`ifdef UART_HOST_ERR_DROP_EN
    check("par_rx_valid_dropped", bus.rx_valid, 0);
    check("par_drop_cnt", err_drop_cnt, 1);
`else
    check("par_rx_valid", bus.rx_valid, 1);
    check("par_rx_err", bus.rx_err, 1);
    check("par_rx_data", bus.rx_data, 8'h77);
    check("par_drop_cnt_zero", err_drop_cnt, 0);
`endif
    uart_parity_err = 1'b0;
    bus.rx_ready    = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
    ticks(3);
    $display("[TB] parity-error read done");

    // Framing error on read
    uart_data_out    = 8'h0F;
    uart_framing_err = 1'b1;
    uart_rxrdy       = 1'b1;
    tick();
    uart_rxrdy = 1'b0;
    tick();
`ifdef UART_HOST_ERR_DROP_EN
    check("frm_drop_cnt", err_drop_cnt, 2);
    uart_rxrdy = 1'b1;
    ticks(1600);
    uart_rxrdy = 1'b0;
    check("frm_drop_cnt_sat", err_drop_cnt, 255);
    check("frm_rx_valid_dropped", bus.rx_valid, 0);
`else
    check("frm_rx_err", bus.rx_err, 1);
    check("frm_rx_data", bus.rx_data, 8'h0F);
`endif
    uart_framing_err = 1'b0;
    bus.rx_ready     = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
    ticks(4);
    $display("[TB] framing-error read done");

    // Overflow sticky: set beats clear, then clear alone
    uart_overflow = 1'b1;
    ovf_clr       = 1'b1;
    tick();
    check("ovf_set_wins", ovf_sticky, 1);
    uart_overflow = 1'b0;
    tick();
    check("ovf_cleared", ovf_sticky, 0);
    ovf_clr       = 1'b0;
    uart_overflow = 1'b1;
    tick();
    uart_overflow = 1'b0;
    ticks(3);
    check("ovf_sticky_holds", ovf_sticky, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr_again", ovf_sticky, 0);
    $display("[TB] overflow sticky checked");

    // Asynchronous reset in the middle of a write strobe
    uart_overflow = 1'b1;
    tick();
    uart_overflow = 1'b0;
    bus.tx_valid  = 1'b1;
    bus.tx_data   = 8'hA5;
    tick();
    check("mid_wr_csn", uart_csn, 0);
    check("mid_wr_data", uart_data_in, 8'hA5);
    #2;
    aresetn = 1'b0;
    #1;
    check("arst_csn", uart_csn, 1);
    check("arst_wen", uart_wen, 1);
    check("arst_data_in", uart_data_in, 0);
    check("arst_ovf", ovf_sticky, 0);
    check("arst_rx_valid", bus.rx_valid, 0);
    bus.tx_valid = 1'b0;
    tick();
    aresetn = 1'b1;
    tick();
    check("post_arst_csn", uart_csn, 1);
    $display("[TB] reset during write done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
